// File: rtl/sc_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the control-section microsequencer:
//   - MIR COND field encodings
//   - instruction-format constants used to decide decode legality
//   - helper function flagging opcodes that have no microcode routine
// -----------------------------------------------------------------------------
package sc_pkg;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

    // Width of the decode address produced by the map: {1, op, op3, 00}
    localparam int DECODE_W = 11;

    // op field (IR[31:30]) value for the branch/sethi format
    localparam logic [1:0] OP_FMT2    = 2'b00;
    // op2 field (IR[24:22]) values implemented within that format
    localparam logic [2:0] OP2_BRANCH = 3'b010;
    localparam logic [2:0] OP2_SETHI  = 3'b100;

    // Only branch and sethi exist in the op=00 format; anything else there
    // has no microcode routine and must be redirected to the trap handler.
    function automatic logic is_unimplemented(input logic [1:0] op,
                                              input logic [2:0] op2);
        logic result;
        if (op == OP_FMT2) begin
            result = (op2 != OP2_BRANCH) && (op2 != OP2_SETHI);
        end else begin
            result = 1'b0;
        end
        return result;
    endfunction

endpackage

// File: rtl/sc_decode_map.sv
// -----------------------------------------------------------------------------
// sc_decode_map
// Combinational map from the instruction register to the microcode entry
// address of the instruction's routine, plus a flag for opcodes that have no
// routine.
//   i_ir            in  32  instruction register
//   o_decode_addr   out 11  entry address {1'b1, op, op3, 2'b00}
//   o_illegal       out 1   opcode has no microcode routine (op=00, neither branch nor sethi)
// -----------------------------------------------------------------------------
module sc_decode_map
    import sc_pkg::*;
(
    input  logic [31:0]         i_ir,
    output logic [DECODE_W-1:0] o_decode_addr,
    output logic                o_illegal
);

    logic [1:0] w_op;
    logic [5:0] w_op3;
    logic [2:0] w_op2;
    logic       w_unused_ir;

    assign w_op  = i_ir[31:30];
    assign w_op3 = i_ir[24:19];
    // op2 overlaps the top of op3 in the op=00 format
    assign w_op2 = i_ir[24:22];

    // Remaining IR bits (rd, operands) do not influence the entry point
    assign w_unused_ir = ^{i_ir[29:25], i_ir[18:0]};

    // Each routine gets a 4-word slot in the upper half of the control store
    assign o_decode_addr = {1'b1, w_op, w_op3, 2'b00};
    assign o_illegal     = is_unimplemented(w_op, w_op2);

endmodule

// File: rtl/sc_microsequencer.sv
// -----------------------------------------------------------------------------
// sc_microsequencer
// Owns the control-store address register and picks the next microinstruction
// address each cycle: increment, conditional/unconditional jump, or decode.
//   SC_MicroSeq_CLOCK_50       in  1       system clock
//   SC_MicroSeq_RESET_InLow    in  1       async active-low reset
//   SC_MicroSeq_Cond           in  3       MIR COND field
//   SC_MicroSeq_JumpAddr       in  ADDR_W  MIR JUMP_ADDR field
//   SC_MicroSeq_BranchTaken    in  1       jump decision from CC_branchControl
//   SC_MicroSeq_Ir             in  32      instruction register
//   SC_MicroSeq_Stall_InHigh   in  1       hold current address (memory wait)
//   SC_MicroSeq_Addr           out ADDR_W  registered control-store address
//   SC_MicroSeq_MirValid       out 1       MIR holds word for previous address
//   SC_MicroSeq_Trap           out 1       pulse when decode goes to TRAP_ADDR
//   SC_MicroSeq_Count          out 16      retired microinstructions, saturating
// -----------------------------------------------------------------------------
module sc_microsequencer
    import sc_pkg::*;
#(
    parameter int                ADDR_W     = 11,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 11'h000,
    parameter logic [ADDR_W-1:0] TRAP_ADDR  = 11'h7FF
)
(
    input  logic              SC_MicroSeq_CLOCK_50,
    input  logic              SC_MicroSeq_RESET_InLow,
    input  logic [2:0]        SC_MicroSeq_Cond,
    input  logic [ADDR_W-1:0] SC_MicroSeq_JumpAddr,
    input  logic              SC_MicroSeq_BranchTaken,
    input  logic [31:0]       SC_MicroSeq_Ir,
    input  logic              SC_MicroSeq_Stall_InHigh,
    output logic [ADDR_W-1:0] SC_MicroSeq_Addr,
    output logic              SC_MicroSeq_MirValid,
    output logic              SC_MicroSeq_Trap,
    output logic [15:0]       SC_MicroSeq_Count
);

    logic [ADDR_W-1:0]   r_addr;
    logic                r_mir_valid;
    logic                r_trap;
    logic [15:0]         r_count;

    logic [DECODE_W-1:0] w_decode_addr;
    logic                w_illegal;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_trap_next;
    logic [15:0]         w_count_next;

    sc_decode_map u_decode_map (
        .i_ir          (SC_MicroSeq_Ir),
        .o_decode_addr (w_decode_addr),
        .o_illegal     (w_illegal)
    );

    // Natural overflow gives the required wrap from the top address to zero
    assign w_addr_inc = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Saturating retire counter
    assign w_count_next = (r_count == 16'hFFFF) ? r_count : (r_count + 16'd1);

    // Next-address select from the COND field of the current MIR word
    always_comb begin
        w_next_addr = w_addr_inc;
        w_trap_next = 1'b0;
        case (cond_e'(SC_MicroSeq_Cond))
            COND_NEXT: begin
                w_next_addr = w_addr_inc;
            end
            COND_N, COND_Z, COND_V, COND_C, COND_IR13: begin
                // BranchTaken already resolves the flag selected by COND
                if (SC_MicroSeq_BranchTaken) begin
                    w_next_addr = SC_MicroSeq_JumpAddr;
                end else begin
                    w_next_addr = w_addr_inc;
                end
            end
            COND_JUMP: begin
                w_next_addr = SC_MicroSeq_JumpAddr;
            end
            COND_DECODE: begin
                if (w_illegal) begin
                    w_next_addr = TRAP_ADDR;
                    w_trap_next = 1'b1;
                end else begin
                    w_next_addr = ADDR_W'(w_decode_addr);
                    w_trap_next = 1'b0;
                end
            end
            default: begin
                w_next_addr = w_addr_inc;
                w_trap_next = 1'b0;
            end
        endcase
    end

    // Address register, MIR-valid flag, trap pulse and retire counter.
    // Stall freezes everything; the first unstalled cycle after reset only
    // marks the MIR valid because the ROM is still filling.
    always_ff @(posedge SC_MicroSeq_CLOCK_50 or negedge SC_MicroSeq_RESET_InLow) begin
        if (!SC_MicroSeq_RESET_InLow) begin
            r_addr      <= RESET_ADDR;
            r_mir_valid <= 1'b0;
            r_trap      <= 1'b0;
            r_count     <= 16'h0000;
        end else if (SC_MicroSeq_Stall_InHigh) begin
            r_trap      <= 1'b0;
        end else if (!r_mir_valid) begin
            r_mir_valid <= 1'b1;
            r_trap      <= 1'b0;
        end else begin
            r_addr      <= w_next_addr;
            r_trap      <= w_trap_next;
            r_count     <= w_count_next;
        end
    end

    assign SC_MicroSeq_Addr     = r_addr;
    assign SC_MicroSeq_MirValid = r_mir_valid;
    assign SC_MicroSeq_Trap     = r_trap;
    assign SC_MicroSeq_Count    = r_count;

endmodule
